// File: rtl/countdown_timer_controller.sv
// countdown_timer_controller: one-shot interval timer with ready/valid command and expiry event ports.
// Optional periodic auto-reload is enabled by defining COUNTDOWN_TIMER_AUTO_RELOAD_EN.
module countdown_timer_controller #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WORD_WIDTH-1:0] cmd_count,
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    input  logic                  cmd_periodic,
`endif
    input  logic                  pause,
    input  logic                  abort,
    output logic                  expired_valid,
    input  logic                  expired_ready,
    output logic                  busy,
    output logic [WORD_WIDTH-1:0] count_remaining
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t                state;
    logic [WORD_WIDTH-1:0] count;
    assign cmd_ready       = (state == IDLE);
    assign expired_valid   = (state == DONE);
    assign busy            = (state != IDLE);
    assign count_remaining = count;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    logic [WORD_WIDTH-1:0] period;
    logic                  periodic;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            period   <= '0;
            periodic <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    count    <= cmd_count;
                    period   <= cmd_count;
                    periodic <= cmd_periodic;
                    state    <= (cmd_count == '0) ? DONE : RUN;
                end
                RUN: if (abort) begin
                    state    <= IDLE;
                    count    <= '0;
                    periodic <= 1'b0;
                end else if (!pause) begin
                    count <= count - WORD_WIDTH'(1);
                    if (count == WORD_WIDTH'(1)) state <= DONE;
                end
                DONE: if (abort) begin
                    state    <= IDLE;
                    periodic <= 1'b0;
                end else if (expired_ready) begin
                    // Periodic timers re-arm from the latched period instead of releasing the block
                    count <= periodic ? period : '0;
                    state <= !periodic ? IDLE : (period == '0) ? DONE : RUN;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    count <= cmd_count;
                    state <= (cmd_count == '0) ? DONE : RUN;
                end
                RUN: if (abort) begin
                    state <= IDLE;
                    count <= '0;
                end else if (!pause) begin
                    // RUN always holds count >= 1, so this decrement cannot wrap
                    count <= count - WORD_WIDTH'(1);
                    if (count == WORD_WIDTH'(1)) state <= DONE;
                end
                DONE: if (abort || expired_ready) state <= IDLE;
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_countdown_timer_controller.sv
// tb_countdown_timer_controller: table-driven check of countdown_timer_controller plus reset and reload sequences.
module tb_countdown_timer_controller;
    localparam int W = 16;
    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_count = '0;
    logic         cmd_periodic = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic         expired_valid;
    logic         expired_ready = 1'b0;
    logic         busy;
    logic [W-1:0] count_remaining;
    int checks = 0;
    int errors = 0;

    countdown_timer_controller #(.WORD_WIDTH(W)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_count(cmd_count),
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        .cmd_periodic(cmd_periodic),
`endif
        .pause(pause),
        .abort(abort),
        .expired_valid(expired_valid),
        .expired_ready(expired_ready),
        .busy(busy),
        .count_remaining(count_remaining)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         valid;
        logic [W-1:0] cnt;
        logic         pse;
        logic         abt;
        logic         er;
        logic         e_ready;
        logic         e_ev;
        logic         e_busy;
        logic [W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, int c, logic p, logic a, logic r,
                                logic xr, logic xe, logic xb, int xc);
        vec_t t;
        t.valid = v; t.cnt = W'(c); t.pse = p; t.abt = a; t.er = r;
        t.e_ready = xr; t.e_ev = xe; t.e_busy = xb; t.e_cnt = W'(xc);
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(string name, logic r, logic e, logic b, logic [W-1:0] c);
        chk({name, ".cmd_ready"}, 32'(cmd_ready), 32'(r));
        chk({name, ".expired_valid"}, 32'(expired_valid), 32'(e));
        chk({name, ".busy"}, 32'(busy), 32'(b));
        chk({name, ".count_remaining"}, 32'(count_remaining), 32'(c));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(logic v, int c, logic per, logic p, logic a, logic r);
        cmd_valid = v; cmd_count = W'(c); cmd_periodic = per; pause = p; abort = a; expired_ready = r;
    endtask

    initial begin
        // one-shot N=5: expiry in cycle 6, ready again in cycle 7; later cmd_count ignored
        vecs.push_back(mk(1, 5, 0, 0, 1,  0, 0, 1, 5));
        vecs.push_back(mk(0, 9, 0, 0, 1,  0, 0, 1, 4));
        vecs.push_back(mk(1, 9, 0, 0, 1,  0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 0, 0, 0));
        // N=0 expires in cycle 1; N=1 in cycle 2, then held 4 cycles without ready
        vecs.push_back(mk(1, 0, 0, 0, 1,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 0, 0, 0));
        // N=3 with two pause cycles at count==1: expiry delayed to cycle 6
        vecs.push_back(mk(1, 3, 0, 0, 0,  0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 0, 0, 0));
        // abort at count==2 wins over pause
        vecs.push_back(mk(1, 3, 0, 0, 0,  0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 1, 1, 0,  1, 0, 0, 0));
        // abort in IDLE ignored; abort with ready in DONE returns to IDLE
        vecs.push_back(mk(1, 0, 0, 1, 0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0));

        step();
        chk_all("reset_hold", 1, 0, 0, 0);
        reset_n = 1'b1;
        step();
        chk_all("reset_release", 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, int'(vecs[i].cnt), 0, vecs[i].pse, vecs[i].abt, vecs[i].er);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_ev, vecs[i].e_busy, vecs[i].e_cnt);
        end

        // reset mid-RUN at count 7
        drive(1, 10, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        chk("pre_reset.count", 32'(count_remaining), 32'd7);
        reset_n = 1'b0;
        #1;
        chk("async_reset.busy", 32'(busy), 32'd0);
        step();
        chk_all("mid_run_reset", 1, 0, 0, 0);
        reset_n = 1'b1;
        step();
        chk_all("after_reset", 1, 0, 0, 0);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        // period 3: events at cycles 3,6,9, then abort
        drive(1, 2, 1, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 1);
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("per_a.ev%0d", c), 32'(expired_valid), 32'(c % 3 == 0));
            chk($sformatf("per_a.ready%0d", c), 32'(cmd_ready), 32'd0);
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("per_a.abort", 1, 0, 0, 0);
        // abort at cycle 7 stops further events
        drive(1, 2, 1, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 1);
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("per_b.ev%0d", c), 32'(expired_valid), 32'(c % 3 == 0));
            if (c == 7) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        for (int c = 8; c <= 11; c++) begin
            chk_all($sformatf("per_b.c%0d", c), 1, 0, 0, 0);
            step();
        end
        // period 0: event stays asserted every ready cycle
        drive(1, 0, 1, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 1);
        for (int c = 1; c <= 4; c++) begin
            chk_all($sformatf("per0.c%0d", c), 0, 1, 1, 0);
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("per0.abort", 1, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
